// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_arith_pkg
//  Purpose  : Shared state encoding and helpers for the bit-serial arithmetic
//             blocks.
//  Revision : 1.0  initial release
// ============================================================================
package serial_arith_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_e;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor_unit.sv
`default_nettype none
// ============================================================================
//  Module   : full_subtractor_unit
//  Purpose  : One-bit full subtractor, D = A - B - Bin with borrow-out.
//  Revision : 1.0  initial release
// ============================================================================
module full_subtractor_unit (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    // Difference bit and borrow generated (A<B) or propagated (A==B).
    always_comb begin
        D    = A ^ B ^ Bin;
        Bout = (~A & B) | (~(A ^ B) & Bin);
    end

endmodule
`default_nettype wire

// File: rtl/serial_sub_unit.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub_unit
//  Purpose  : Bit-serial two's-complement subtractor, DIFF = A - B - Bin,
//             one bit per clock LSB first, with start/busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module serial_sub_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    import serial_arith_pkg::*;

    localparam int                 c_CNT_W = clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    state_e             r_state;
    state_e             w_next_state;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_res_sr;
    logic               r_borrow;
    logic [c_CNT_W-1:0] r_count;
    logic               w_d;
    logic               w_bout;
    logic [WIDTH-1:0]   w_result;

    full_subtractor_unit u_cell (
        .A    (r_a_sr[0]),
        .B    (r_b_sr[0]),
        .Bin  (r_borrow),
        .D    (w_d),
        .Bout (w_bout)
    );

    // The final bit joins the bits already shifted in to form the full result.
    assign w_result = {w_d, r_res_sr[WIDTH-1:1]};

    // Next-state logic; start is only honoured when no operation is in flight.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_count == c_LAST) begin
                    w_last       = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_SHIFT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand load on accept, otherwise shift one bit per SHIFT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
        end else if (w_accept) begin
            r_a_sr   <= a_in;
            r_b_sr   <= b_in;
            r_borrow <= bin_in;
            r_count  <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_res_sr <= w_result;
            r_borrow <= w_bout;
            r_count  <= r_count + 1'b1;
        end
    end

    // Registered handshake flags and result, updated only on the last bit.
    // At that point r_a_sr[0]/r_b_sr[0] hold the latched operand MSBs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            busy <= (w_next_state == S_SHIFT);
            done <= (w_next_state == S_DONE);
            if (w_last) begin
                diff <= w_result;
                bout <= w_bout;
                ovf  <= (r_a_sr[0] ^ r_b_sr[0]) & (r_a_sr[0] ^ w_d);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_sub_unit
//  Purpose  : Self-checking bench for serial_sub_unit (WIDTH=8 and WIDTH=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_sub_unit;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       bin8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       bout8;
    logic       ovf8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       bin4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       bout4;
    logic       ovf4;

    int checks;
    int errors;

    serial_sub_unit #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .a_in   (a8),
        .b_in   (b8),
        .bin_in (bin8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
        .bout   (bout8),
        .ovf    (ovf8)
    );

    serial_sub_unit #(.WIDTH(4)) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start4),
        .a_in   (a4),
        .b_in   (b4),
        .bin_in (bin4),
        .busy   (busy4),
        .done   (done4),
        .diff   (diff4),
        .bout   (bout4),
        .ovf    (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic. Returns {ovf, bout, diff[31:0]}.
    function automatic logic [33:0] ref_sub(input int w, input longint a,
                                            input longint b, input longint bin);
        longint half, mask, full, sa, sb, sr;
        logic   o, bo;
        half = longint'(1) << (w - 1);
        mask = (longint'(1) << w) - 1;
        full = (a - b - bin) & mask;
        bo   = (a < (b + bin));
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        sr   = sa - sb - bin;
        o    = (sr < -half) || (sr > half - 1);
        return {o, bo, 32'(full)};
    endfunction

    // Issue one WIDTH=8 operation from a point just after a clock edge and
    // wait (bounded) for done.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output int lat, output int busy_cnt, output logic accept_ok);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        accept_ok = (busy8 === 1'b1) && (done8 === 1'b0);
        busy_cnt  = (busy8 === 1'b1) ? 1 : 0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy8 === 1'b1 && done8 !== 1'b1) busy_cnt++;
        end
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        output int lat);
        a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 0;
        while (done4 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done8); end
        checks++; if (diff8 !== 8'h00) begin errors++; $display("FAIL reset_diff got %h exp 00", diff8); end
        checks++; if (bout8 !== 1'b0) begin errors++; $display("FAIL reset_bout got %b exp 0", bout8); end
        checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf8); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [7:0] ta [5] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h33};
        logic [7:0] tb [5] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h44};
        logic       tn [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] td [5] = '{8'h02, 8'hFE, 8'h7F, 8'h80, 8'hEE};
        logic       tbo[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic       tov[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int lat, bc;
        logic acc;
        for (int i = 0; i < 5; i++) begin
            run8(ta[i], tb[i], tn[i], lat, bc, acc);
            checks++; if (lat != 8) begin errors++; $display("FAIL dir_latency[%0d] got %0d exp 8", i, lat); end
            checks++; if (bc != 8) begin errors++; $display("FAIL dir_busy_cycles[%0d] got %0d exp 8", i, bc); end
            checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL dir_busy_at_done[%0d] got %b exp 0", i, busy8); end
            checks++; if (diff8 !== td[i]) begin errors++; $display("FAIL dir_diff[%0d] got %h exp %h", i, diff8, td[i]); end
            checks++; if (bout8 !== tbo[i]) begin errors++; $display("FAIL dir_bout[%0d] got %b exp %b", i, bout8, tbo[i]); end
            checks++; if (ovf8 !== tov[i]) begin errors++; $display("FAIL dir_ovf[%0d] got %b exp %b", i, ovf8, tov[i]); end
            @(posedge clk); #1;
            checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL dir_done_pulse[%0d] got %b exp 0", i, done8); end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic acc;
        run8(8'h00, 8'h00, 1'b1, lat, bc, acc);
        checks++; if (diff8 !== 8'hFF || bout8 !== 1'b1 || ovf8 !== 1'b0) begin
            errors++; $display("FAIL b2b_first got %h/%b/%b exp ff/1/0", diff8, bout8, ovf8); end
        run8(8'hAA, 8'h55, 1'b0, lat, bc, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b exp 1", acc); end
        checks++; if (lat != 8) begin errors++; $display("FAIL b2b_latency got %0d exp 8", lat); end
        checks++; if (diff8 !== 8'h55) begin errors++; $display("FAIL b2b_diff got %h exp 55", diff8); end
        checks++; if (bout8 !== 1'b0) begin errors++; $display("FAIL b2b_bout got %b exp 0", bout8); end
        checks++; if (ovf8 !== 1'b1) begin errors++; $display("FAIL b2b_ovf got %b exp 1", ovf8); end
    endtask

    task automatic test_ignored_start();
        int n, dcnt, lat;
        @(posedge clk); #1;
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        checks++; if (diff8 !== 8'h55) begin errors++; $display("FAIL ign_hold_early got %h exp 55", diff8); end
        dcnt = 0; lat = -1;
        for (n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 3) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'h33; bin8 = 1'b1; end
            if (n == 4) start8 = 1'b0;
            if (done8 === 1'b1) begin
                dcnt++;
                if (lat < 0) lat = n;
            end else if (dcnt == 0 && n < 8) begin
                checks++; if (diff8 !== 8'h55) begin errors++; $display("FAIL ign_hold[%0d] got %h exp 55", n, diff8); end
            end
        end
        checks++; if (dcnt != 1) begin errors++; $display("FAIL ign_done_count got %0d exp 1", dcnt); end
        checks++; if (lat != 8) begin errors++; $display("FAIL ign_latency got %0d exp 8", lat); end
        checks++; if (diff8 !== 8'h0F || bout8 !== 1'b0 || ovf8 !== 1'b0) begin
            errors++; $display("FAIL ign_result got %h/%b/%b exp 0f/0/0", diff8, bout8, ovf8); end
    endtask

    task automatic test_reset_mid();
        int dcnt, lat, bc;
        logic acc;
        a8 = 8'hF0; b8 = 8'h01; bin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++; $display("FAIL rstmid_flags got busy %b done %b exp 0 0", busy8, done8); end
        checks++; if (diff8 !== 8'h00 || bout8 !== 1'b0 || ovf8 !== 1'b0) begin
            errors++; $display("FAIL rstmid_result got %h/%b/%b exp 00/0/0", diff8, bout8, ovf8); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dcnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 === 1'b1 || busy8 === 1'b1) dcnt++;
        end
        checks++; if (dcnt != 0) begin errors++; $display("FAIL rstmid_no_done got %0d active cycles exp 0", dcnt); end
        run8(8'h12, 8'h34, 1'b0, lat, bc, acc);
        checks++; if (lat != 8) begin errors++; $display("FAIL rstmid_latency got %0d exp 8", lat); end
        checks++; if (diff8 !== 8'hDE || bout8 !== 1'b1 || ovf8 !== 1'b0) begin
            errors++; $display("FAIL rstmid_after got %h/%b/%b exp de/1/0", diff8, bout8, ovf8); end
    endtask

    task automatic test_random();
        logic [7:0]  ra, rb;
        logic        rn;
        logic [33:0] exp;
        int lat, bc;
        logic acc;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
            ra = 8'($urandom); rb = 8'($urandom); rn = 1'($urandom);
            exp = ref_sub(8, longint'(ra), longint'(rb), longint'(rn));
            run8(ra, rb, rn, lat, bc, acc);
            checks++; if (lat != 8) begin errors++; $display("FAIL rnd_latency[%0d] got %0d exp 8", i, lat); end
            checks++; if (diff8 !== exp[7:0]) begin errors++; $display("FAIL rnd_diff[%0d] %h-%h-%b got %h exp %h", i, ra, rb, rn, diff8, exp[7:0]); end
            checks++; if (bout8 !== exp[32]) begin errors++; $display("FAIL rnd_bout[%0d] %h-%h-%b got %b exp %b", i, ra, rb, rn, bout8, exp[32]); end
            checks++; if (ovf8 !== exp[33]) begin errors++; $display("FAIL rnd_ovf[%0d] %h-%h-%b got %b exp %b", i, ra, rb, rn, ovf8, exp[33]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep4();
        logic [33:0] exp;
        int lat;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int in = 0; in < 2; in++) begin
                    exp = ref_sub(4, longint'(ia), longint'(ib), longint'(in));
                    run4(4'(ia), 4'(ib), 1'(in), lat);
                    checks++; if (lat != 4) begin errors++; $display("FAIL sw4_latency %0d-%0d-%0d got %0d exp 4", ia, ib, in, lat); end
                    checks++; if (diff4 !== exp[3:0] || bout4 !== exp[32] || ovf4 !== exp[33]) begin
                        errors++;
                        $display("FAIL sw4_result %0d-%0d-%0d got %h/%b/%b exp %h/%b/%b",
                                 ia, ib, in, diff4, bout4, ovf4, exp[3:0], exp[32], exp[33]);
                    end
                end
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        rst_n  = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid();
        test_random();
        test_sweep4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
